load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the synchronous data memory.
- Accepts one load/store request at a time over a valid/ready handshake and computes the effective address.
- Checks alignment, generates byte enables and lane-shifted store data, and issues the access.
- Captures the 1-cycle-latency read data, then byte-selects and sign/zero-extends it for writeback.
- Returns a response over a second valid/ready handshake.

Parameters:
- XLEN, 32, data/address width.
- ADDR_WIDTH, 8, word-index width of the data memory (2^ADDR_WIDTH words).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32 width/sign code.
- req_base  in  XLEN  rs1 value.
- req_offset  in  XLEN  sign-extended immediate.
- req_wdata  in  XLEN  rs2 value (stores).
- req_rd  in  5  destination register (loads).
- mem_addr  out  ADDR_WIDTH  word index to data memory.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_rdata  in  XLEN  read word, valid the cycle after mem_en with mem_we=0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  writeback accepts the response.
- rsp_wb  out  1  response writes a register (loads without fault).
- rsp_rd  out  5  destination register.
- rsp_data  out  XLEN  formatted load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned or illegal-funct3 access.

Behaviour:
- Address computation:
  - ea = req_base + req_offset, modulo 2^32, computed on acceptance.
  - mem_addr = ea[ADDR_WIDTH+1:2]; upper bits ignored, so wrap-around is natural.
  - Lane = ea[1:0].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and sets rsp_fault.
- Alignment:
  - Halfword requires ea[0]=0; word requires ea[1:0]=0 (see Optional Feature).
- Store encoding:
  - SB: be=0001<<lane, wdata=rs2[7:0] replicated ×4.
  - SH: be=0011<<lane, wdata=rs2[15:0] replicated ×2.
  - SW: be=1111, wdata=rs2.
- Load formatting:
  - Byte selected by mem_rdata>>(8*lane).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- FSM states: IDLE, ISSUE, DATA, RESP.
  - IDLE: req_ready=1. On req_valid, latch all request fields and ea. Go to RESP if faulted, else to ISSUE.
  - ISSUE: mem_en=1, mem_we=req_we, mem_be per encoding (loads drive 1111). Store goes to RESP; load goes to DATA.
  - DATA: mem_rdata is registered and formatted into rsp_data; go to RESP.
  - RESP: rsp_valid=1 with all rsp_* held stable. On rsp_ready, go to IDLE.
- Latency, with acceptance at cycle T:
  - Fault: rsp_valid at T+1.
  - Store: write at T+1, rsp_valid at T+2.
  - Load: rsp_valid at T+3.
- Output defaults:
  - Outside ISSUE: mem_en=0, mem_we=0, mem_be=0, mem_wdata=0, mem_addr=latched index.
  - req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
- Response flags:
  - Stores: rsp_wb=0, rsp_data=0.
  - Faults: rsp_wb=0, rsp_data=0, rsp_fault=1, no memory access at all.
- Back-to-back: a new request is accepted only in IDLE, so the earliest acceptance is the cycle after the RESP handshake.
- Reset:
  - State goes to IDLE; all registered rsp_* fields and latched request fields clear to 0.
  - Outputs after reset: req_ready=1, rsp_valid=0, mem_en=0, mem_we=0, mem_be=0.
  - Reset mid-operation, including during ISSUE, abandons the transaction. Memory write is suppressed the cycle rst is high.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned halfword/word accesses fault: rsp_fault=1, no memory access.
- Undefined:
  - The address is force-aligned (LH/LHU/SH clear ea[0]; LW/SW clear ea[1:0]) and the access proceeds.
  - rsp_fault is set only for illegal funct3.

Test Plan:
- Reset held 2 cycles → req_ready=1, rsp_valid=0, mem_en=0, mem_be=0.
- SW base=0x100, off=0x4, wdata=0xDEADBEEF → ISSUE cycle mem_addr=0x41, be=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_wb=0.
- Word 0x41 holds 0x80FF7F01:
  - LB ea=0x106 → rsp_data=0xFFFFFFFF.
  - LBU ea=0x107 → 0x00000080.
  - LH ea=0x106 → 0xFFFF80FF.
  - LHU ea=0x104 → 0x00007F01.
  - Each response arrives 3 cycles after accept with rsp_wb=1 and rsp_rd echoed.
- SB ea=0x103, wdata=0x000000AB → be=1000, mem_wdata=0xABABABAB.
- Misaligned access:
  - LW ea=0x102 with MISALIGN_TRAP_EN → rsp_fault=1 at T+1, mem_en never asserted.
  - Same access without the macro → mem_addr=0x40 read, rsp_fault=0.
- Illegal funct3=011 load → rsp_fault=1 in both builds.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0; release → accept the next request the following cycle.
- Assert rst during ISSUE of a store → memory not written; state returns to IDLE.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and response signals of the LSU.
// slave is the LSU side; master is the execute/memory/writeback side.
interface load_store_unit_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [XLEN-1:0]       req_base;
    logic [XLEN-1:0]       req_offset;
    logic [XLEN-1:0]       req_wdata;
    logic [4:0]            req_rd;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN-1:0]       mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_wb;
    logic [4:0]            rsp_rd;
    logic [XLEN-1:0]       rsp_data;
    logic                  rsp_fault;

    modport slave (
        input  req_valid, req_we, req_funct3, req_base,
        input  req_offset, req_wdata, req_rd,
        output req_ready,
        output mem_addr, mem_en, mem_we, mem_be, mem_wdata,
        input  mem_rdata,
        output rsp_valid, rsp_wb, rsp_rd, rsp_data, rsp_fault,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_we, req_funct3, req_base,
        output req_offset, req_wdata, req_rd,
        input  req_ready,
        input  mem_addr, mem_en, mem_we, mem_be, mem_wdata,
        output mem_rdata,
        input  rsp_valid, rsp_wb, rsp_rd, rsp_data, rsp_fault,
        output rsp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine to a synchronous data memory.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        RESP
    } state_e;

    state_e                state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  req_ready_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [3:0]            mem_be_q;
    logic [XLEN-1:0]       mem_wdata_q;

    logic                  rsp_valid_q;
    logic                  rsp_wb_q;
    logic [4:0]            rsp_rd_q;
    logic [XLEN-1:0]       rsp_data_q;
    logic                  rsp_fault_q;

    logic [XLEN-1:0]       ea_d;
    logic [1:0]            lane_d;
    logic [3:0]            be_d;
    logic [XLEN-1:0]       wdata_d;
    logic                  illegal_d;
    logic                  fault_d;
    logic [XLEN-1:0]       shifted_d;
    logic [XLEN-1:0]       load_d;
    logic                  unused_ea;

    assign ea_d      = bus.req_base + bus.req_offset;
    assign unused_ea = ^ea_d[XLEN-1:ADDR_WIDTH+2];

    assign illegal_d = (bus.req_funct3 == 3'b011)
                     | (bus.req_funct3[2:1] == 2'b11)
                     | (bus.req_we & bus.req_funct3[2]);

`ifdef MISALIGN_TRAP_EN
    logic misal_d;
    assign misal_d = ((bus.req_funct3[1:0] == 2'b01) & ea_d[0])
                   | ((bus.req_funct3[1:0] == 2'b10) & (|ea_d[1:0]));
    assign fault_d = illegal_d | misal_d;
`else
    assign fault_d = illegal_d;
`endif

    // Halfword/word lanes are force-aligned; with trapping enabled a
    // misaligned request faults first, so the aligned lane is never used.
    always_comb begin
        lane_d  = ea_d[1:0];
        be_d    = 4'b0001 << ea_d[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
        unique case (bus.req_funct3[1:0])
            2'b01: begin
                lane_d  = {ea_d[1], 1'b0};
                be_d    = 4'b0011 << {ea_d[1], 1'b0};
                wdata_d = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                lane_d  = 2'b00;
                be_d    = 4'b1111;
                wdata_d = bus.req_wdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        shifted_d = bus.mem_rdata >> {lane_q, 3'b000};
        load_d    = shifted_d;
        unique case (f3_q)
            3'b000: load_d = {{(XLEN-8){shifted_d[7]}}, shifted_d[7:0]};
            3'b001: load_d = {{(XLEN-16){shifted_d[15]}}, shifted_d[15:0]};
            3'b100: load_d = {{(XLEN-8){1'b0}}, shifted_d[7:0]};
            3'b101: load_d = {{(XLEN-16){1'b0}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wb_q    <= 1'b0;
            rsp_rd_q    <= 5'd0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        f3_q        <= bus.req_funct3;
                        lane_q      <= lane_d;
                        addr_q      <= ea_d[ADDR_WIDTH+1:2];
                        req_ready_q <= 1'b0;
                        rsp_wb_q    <= 1'b0;
                        rsp_rd_q    <= bus.req_rd;
                        rsp_data_q  <= '0;
                        rsp_fault_q <= fault_d;
                        if (fault_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_be_q    <= bus.req_we ? be_d : 4'b1111;
                            mem_wdata_q <= bus.req_we ? wdata_d : '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= 4'b0000;
                    mem_wdata_q <= '0;
                    if (we_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_wb_q    <= 1'b1;
                    rsp_data_q  <= load_d;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A reset landing on the issue cycle must not commit the write.
    assign bus.mem_en    = mem_en_q & ~rst;
    assign bus.mem_we    = mem_we_q & ~rst;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_addr  = addr_q;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wb    = rsp_wb_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a
// transaction-level model with a shadow memory, checked every cycle.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32), .ADDR_WIDTH(8)) bus ();
    load_store_unit #(.XLEN(32), .ADDR_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    bit          mem_init = 1'b0;
    bit          sh_init  = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // synchronous data memory, one cycle read latency
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= $urandom();
            mem_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_be);
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // transaction model state
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_L = 0;
    bit          hs_req = 1'b0;
    logic        e_fault, e_wb, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_wdata;
    logic [7:0]  e_addr;
    logic [7:0]  m_last = 8'h00;
    logic [3:0]  e_be;
    bit          iss, resp;

    task automatic predict();
        logic [31:0] ea, wd, w, v, mask;
        logic [2:0]  f3;
        int size, lane;
        bit legal, mis;
        f3    = bus.req_funct3;
        wd    = bus.req_wdata;
        ea    = bus.req_base + bus.req_offset;
        size  = 1 << f3[1:0];
        lane  = int'(ea[1:0]);
        legal = bus.req_we ? (f3 <= 3'd2)
                           : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (lane % size) != 0;
`ifdef MISALIGN_TRAP_EN
        e_fault = !legal || mis;
`else
        e_fault = !legal;
        lane    = lane - (lane % size);
`endif
        e_addr = ea[9:2];
        e_we   = bus.req_we;
        e_rd   = bus.req_rd;
        if (bus.req_we) begin
            e_be = 4'(((1 << size) - 1) << lane);
            for (int b = 0; b < 4; b++)
                e_wdata[8*b +: 8] = wd[8*(b % size) +: 8];
        end else begin
            e_be    = 4'hF;
            e_wdata = 32'h0;
        end
        w = shadow[e_addr];
        v = w >> (8 * lane);
        if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
        end
        e_wb   = !bus.req_we && !e_fault;
        e_data = e_wb ? v : 32'h0;
        m_L    = e_fault ? 1 : (bus.req_we ? 2 : 3);
        m_last = e_addr;
    endtask

    always @(negedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < 256; i++) shadow[i] = mem[i];
            sh_init = 1'b1;
        end
        if (rst) begin
            chk("rst_mem_gate", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
            m_busy = 1'b0;
            m_last = 8'h00;
            hs_req = 1'b0;
        end else begin
            iss  = m_busy && m_k == 1 && !e_fault;
            resp = m_busy && m_k >= m_L;
            chk("req_ready", bus.req_ready, !m_busy);
            chk("rsp_valid", bus.rsp_valid, resp);
            chk("mem_en", bus.mem_en, iss);
            chk("mem_we", bus.mem_we, iss && e_we);
            chk("mem_be", bus.mem_be, iss ? e_be : 4'h0);
            chk("mem_wdata", bus.mem_wdata, iss ? e_wdata : 32'h0);
            chk("mem_addr", bus.mem_addr, m_last);
            if (resp) begin
                chk("rsp_wb", bus.rsp_wb, e_wb);
                chk("rsp_rd", bus.rsp_rd, e_rd);
                chk("rsp_data", bus.rsp_data, e_data);
                chk("rsp_fault", bus.rsp_fault, e_fault);
            end
            if (iss && e_we) shadow[e_addr] = merge(shadow[e_addr], e_wdata, e_be);
            hs_req = !m_busy && bus.req_valid;
            if (m_busy) begin
                if (resp && bus.rsp_ready) m_busy = 1'b0;
                else m_k++;
            end else if (hs_req) begin
                predict();
                m_busy = 1'b1;
                m_k    = 1;
            end
        end
    end

    // results captured by send()
    logic [31:0] r_data, r_wdata;
    logic        r_fault, r_wb, r_en;
    logic [4:0]  r_rd;
    logic [7:0]  r_addr;
    logic [3:0]  r_be;
    int          r_lat;

    // call at posedge+1; returns at posedge+1 after the response handshake
    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int hold);
        int n;
        bit ok;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = hs_req;
        end
        bus.req_valid  = 1'b0;
        chk("accepted", ok, 1'b1);
        if (!ok) return;
        bus.req_we     = 1'($urandom());
        bus.req_funct3 = 3'($urandom());
        bus.req_base   = $urandom();
        bus.req_offset = $urandom();
        bus.req_wdata  = $urandom();
        bus.req_rd     = 5'($urandom());
        r_en    = bus.mem_en;
        r_addr  = bus.mem_addr;
        r_be    = bus.mem_be;
        r_wdata = bus.mem_wdata;
        n  = 1;
        ok = 1'b0;
        while (n < 20) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_arrived", ok, 1'b1);
        r_lat   = n;
        r_data  = bus.rsp_data;
        r_fault = bus.rsp_fault;
        r_wb    = bus.rsp_wb;
        r_rd    = bus.rsp_rd;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] saved;
    logic [31:0] imm;
    bit          ok2;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_base   = 32'h0;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        bus.rsp_ready  = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", bus.req_ready, 1'b1);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_mem_en", bus.mem_en, 1'b0);
        chk("reset_mem_be", bus.mem_be, 4'h0);

        send(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd5, 0);
        chk("sw_addr", r_addr, 8'h41);
        chk("sw_be", r_be, 4'hF);
        chk("sw_wdata", r_wdata, 32'hDEADBEEF);
        chk("sw_lat", r_lat, 2);
        chk("sw_wb", r_wb, 1'b0);

        send(1'b1, 3'b010, 32'h100, 32'h4, 32'h80FF7F01, 5'd0, 0);
        send(1'b0, 3'b000, 32'h100, 32'h6, 32'h0, 5'd7, 0);
        chk("lb_data", r_data, 32'hFFFFFFFF);
        chk("lb_lat", r_lat, 3);
        chk("lb_wb", r_wb, 1'b1);
        chk("lb_rd", r_rd, 5'd7);
        send(1'b0, 3'b100, 32'h100, 32'h7, 32'h0, 5'd8, 0);
        chk("lbu_data", r_data, 32'h00000080);
        send(1'b0, 3'b001, 32'h106, 32'h0, 32'h0, 5'd9, 0);
        chk("lh_data", r_data, 32'hFFFF80FF);
        send(1'b0, 3'b101, 32'h108, 32'hFFFFFFFC, 32'h0, 5'd10, 0);
        chk("lhu_data", r_data, 32'h00007F01);
        chk("lhu_lat", r_lat, 3);

        send(1'b1, 3'b000, 32'h103, 32'h0, 32'h000000AB, 5'd0, 0);
        chk("sb_be", r_be, 4'b1000);
        chk("sb_wdata", r_wdata, 32'hABABABAB);

        send(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd11, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_fault", r_fault, 1'b1);
        chk("mis_lat", r_lat, 1);
        chk("mis_no_access", r_en, 1'b0);
`else
        chk("mis_fault", r_fault, 1'b0);
        chk("mis_addr", r_addr, 8'h40);
        chk("mis_en", r_en, 1'b1);
        chk("mis_lat", r_lat, 3);
`endif

        send(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd12, 0);
        chk("ill_fault", r_fault, 1'b1);
        chk("ill_lat", r_lat, 1);
        chk("ill_wb", r_wb, 1'b0);

        send(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5'd13, 5);
        chk("stall_data", r_data, 32'h80FF7F01);
        chk("stall_ready_after", bus.req_ready, 1'b1);

        // reset during the issue cycle of a store
        saved = mem[8'h50];
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_base   = 32'h140;
        bus.req_offset = 32'h0;
        bus.req_wdata  = ~saved;
        bus.req_rd     = 5'd3;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = 1'b1;
        ok2 = 1'b0;
        for (int i = 0; i < 20 && !ok2; i++) begin
            @(posedge clk); #1;
            ok2 = hs_req;
        end
        bus.req_valid = 1'b0;
        chk("rst_store_accepted", ok2, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_nowrite", mem[8'h50], saved);
        chk("rst_idle_ready", bus.req_ready, 1'b1);
        chk("rst_idle_valid", bus.rsp_valid, 1'b0);
        send(1'b0, 3'b010, 32'h140, 32'h0, 32'h0, 5'd4, 0);
        chk("rst_readback", r_data, saved);

        for (int t = 0; t < 400; t++) begin
            imm = $urandom_range(0, 4095);
            if (imm[11]) imm = imm | 32'hFFFFF000;
            send(1'($urandom()), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2047)),
                 imm, $urandom(), 5'($urandom()), $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
